midi_voice_allocator: RTL and testbench

//   Polyphonic voice scheduler between midi_perser and the synth voice bank. Takes decoded

---
 rtl/midi_voice_allocator.sv | 271 +++++++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// ---------------------------------------------------------------------------
// midi_voice_allocator
//
// Polyphonic voice scheduler between the MIDI parser and the synth voice bank.
// Each accepted note event is resolved against the current voice table by a
// sequential scan, one voice per clock. The scan looks for three things:
//   - a voice already holding the same note on the same channel (retrigger)
//   - the lowest-numbered free voice
//   - the oldest voice (steal candidate)
// A commit cycle then applies the event. While the scan and the commit are in
// progress the allocator is busy, and any qualifying event that arrives then
// is dropped and flagged.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   v_valid             1-cycle event strobe from the parser
//   v_channel           event channel
//   v_note_on/_off      event type (exactly one must be set)
//   v_note_num          note number
//   v_note_velocity     velocity (note-on with velocity 0 acts as note-off)
//   panic               1-cycle all-notes-off; aborts any scan in progress
//   busy                high while an event is being scanned or committed
//   ev_dropped          1-cycle pulse: a qualifying event arrived while busy
//   voice_gate          per-voice gate (note held)
//   voice_trig          per-voice 1-cycle pulse on note-on (re)assignment
//   voice_note          per-voice note number, voice i at [7i+6:7i]
//   voice_vel           per-voice velocity,   voice i at [7i+6:7i]
//   voice_chan          per-voice channel,    voice i at [4i+3:4i]
// ---------------------------------------------------------------------------
module midi_voice_allocator #(
  parameter int         NUM_VOICES = 4,
  parameter int         AGE_W      = 4,
  parameter bit         OMNI       = 1'b1,
  parameter logic [3:0] RX_CHANNEL = 4'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    v_valid,
  input  logic [3:0]              v_channel,
  input  logic                    v_note_on,
  input  logic                    v_note_off,
  input  logic [6:0]              v_note_num,
  input  logic [6:0]              v_note_velocity,
  input  logic                    panic,
  output logic                    busy,
  output logic                    ev_dropped,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [4*NUM_VOICES-1:0] voice_chan
);

  localparam int               IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Control state
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Latched event
  logic [3:0]       ev_chan_q, ev_chan_d;
  logic [6:0]       ev_note_q, ev_note_d;
  logic [6:0]       ev_vel_q, ev_vel_d;
  logic             ev_on_q, ev_on_d;

  // Scan results
  logic             match_found_q, match_found_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_found_q, free_found_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic [IDX_W-1:0] oldest_idx_q, oldest_idx_d;
  logic [AGE_W-1:0] oldest_age_q, oldest_age_d;

  // Voice table
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [6:0]            vel_d  [NUM_VOICES];
  logic [3:0]            chan_q [NUM_VOICES];
  logic [3:0]            chan_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];

  logic             dropped_q, dropped_d;
  logic             ev_qual;
  logic [IDX_W-1:0] target_idx;

  assign ev_qual = v_valid & (v_note_on ^ v_note_off) &
                   (OMNI | (v_channel == RX_CHANNEL));

  // Priority: retrigger a held copy of the note, else the lowest free voice,
  // else steal the oldest.
  assign target_idx = match_found_q ? match_idx_q :
                      free_found_q  ? free_idx_q  : oldest_idx_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_chan_d     = ev_chan_q;
    ev_note_d     = ev_note_q;
    ev_vel_d      = ev_vel_q;
    ev_on_d       = ev_on_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    gate_d        = gate_q;
    trig_d        = '0;
    note_d        = note_q;
    vel_d         = vel_q;
    chan_d        = chan_q;
    age_d         = age_q;
    dropped_d     = 1'b0;

    if (panic) begin
      // Abort everything; a simultaneous event is neither accepted nor
      // reported as dropped.
      state_d = ST_IDLE;
      idx_d   = '0;
      gate_d  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_qual) begin
            ev_chan_d     = v_channel;
            ev_note_d     = v_note_num;
            ev_vel_d      = v_note_velocity;
            ev_on_d       = v_note_on & (v_note_velocity != 7'd0);
            match_found_d = 1'b0;
            match_idx_d   = '0;
            free_found_d  = 1'b0;
            free_idx_d    = '0;
            oldest_idx_d  = '0;
            oldest_age_d  = '0;
            idx_d         = '0;
            state_d       = ST_SCAN;
          end
        end

        ST_SCAN: begin
          dropped_d = ev_qual;
          if (!match_found_q && gate_q[idx_q] &&
              (chan_q[idx_q] == ev_chan_q) && (note_q[idx_q] == ev_note_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end
          if (!free_found_q && !gate_q[idx_q]) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          // Strict compare keeps the lowest index on equal ages; the tracker
          // starts at voice 0 with age 0 so voice 0 wins an all-zero table.
          if (age_q[idx_q] > oldest_age_q) begin
            oldest_age_d = age_q[idx_q];
            oldest_idx_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end

        ST_COMMIT: begin
          dropped_d = ev_qual;
          state_d   = ST_IDLE;
          if (ev_on_q) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (target_idx == IDX_W'(i)) begin
                gate_d[i] = 1'b1;
                trig_d[i] = 1'b1;
                note_d[i] = ev_note_q;
                vel_d[i]  = ev_vel_q;
                chan_d[i] = ev_chan_q;
                age_d[i]  = '0;
              end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end else begin
            // Release every held copy, not just the first match.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (gate_q[i] && (chan_q[i] == ev_chan_q) && (note_q[i] == ev_note_q)) begin
                gate_d[i] = 1'b0;
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      ev_chan_q     <= '0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      ev_on_q       <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      gate_q        <= '0;
      trig_q        <= '0;
      dropped_q     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        chan_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_chan_q     <= ev_chan_d;
      ev_note_q     <= ev_note_d;
      ev_vel_q      <= ev_vel_d;
      ev_on_q       <= ev_on_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      gate_q        <= gate_d;
      trig_q        <= trig_d;
      dropped_q     <= dropped_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      chan_q        <= chan_d;
      age_q         <= age_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign ev_dropped = dropped_q;
  assign voice_gate = gate_q;
  assign voice_trig = trig_q;

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
      assign voice_note[7*gi +: 7] = note_q[gi];
      assign voice_vel[7*gi +: 7]  = vel_q[gi];
      assign voice_chan[4*gi +: 4] = chan_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_midi_voice_allocator.sv
`timescale 1ns/1ps
module tb_midi_voice_allocator;

  localparam int         N       = 4;
  localparam int         AGE_W   = 4;
  localparam bit         OMNI    = 1'b1;
  localparam logic [3:0] RX_CH   = 4'd0;
  localparam int         AGE_MAX = (1 << AGE_W) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           v_valid = 1'b0;
  logic [3:0]     v_channel = '0;
  logic           v_note_on = 1'b0;
  logic           v_note_off = 1'b0;
  logic [6:0]     v_note_num = '0;
  logic [6:0]     v_note_velocity = '0;
  logic           panic = 1'b0;
  logic           busy;
  logic           ev_dropped;
  logic [N-1:0]   voice_gate;
  logic [N-1:0]   voice_trig;
  logic [7*N-1:0] voice_note;
  logic [7*N-1:0] voice_vel;
  logic [4*N-1:0] voice_chan;

  always #5 clk = ~clk;

  midi_voice_allocator #(
    .NUM_VOICES(N), .AGE_W(AGE_W), .OMNI(OMNI), .RX_CHANNEL(RX_CH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .v_valid(v_valid), .v_channel(v_channel),
    .v_note_on(v_note_on), .v_note_off(v_note_off),
    .v_note_num(v_note_num), .v_note_velocity(v_note_velocity),
    .panic(panic), .busy(busy), .ev_dropped(ev_dropped),
    .voice_gate(voice_gate), .voice_trig(voice_trig),
    .voice_note(voice_note), .voice_vel(voice_vel), .voice_chan(voice_chan)
  );

  int errors = 0;
  int checks = 0;

  // Event-level reference: a voice table plus a countdown of edges until the
  // pending event takes effect.
  bit     m_gate [N];
  int     m_note [N];
  int     m_vel  [N];
  int     m_chan [N];
  int     m_age  [N];
  bit [N-1:0] m_trig;
  bit     m_drop;
  int     m_busy_left;
  int     p_chan, p_note, p_vel;
  bit     p_on;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_chan[i] = 0; m_age[i] = 0;
    end
    m_trig = '0; m_drop = 0; m_busy_left = 0;
  endtask

  task automatic model_commit();
    int tgt;
    tgt = -1;
    if (p_on) begin
      for (int i = 0; i < N; i++)
        if (tgt < 0 && m_gate[i] && m_chan[i] == p_chan && m_note[i] == p_note) tgt = i;
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < N; i++) if (m_age[i] > m_age[tgt]) tgt = i;
      end
      for (int i = 0; i < N; i++) begin
        if (i == tgt) begin
          m_gate[i] = 1; m_note[i] = p_note; m_vel[i] = p_vel; m_chan[i] = p_chan;
          m_age[i] = 0; m_trig[i] = 1'b1;
        end else if (m_age[i] < AGE_MAX) begin
          m_age[i] = m_age[i] + 1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (m_gate[i] && m_chan[i] == p_chan && m_note[i] == p_note) m_gate[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit qual;
    m_trig = '0;
    m_drop = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    qual = v_valid && (v_note_on ^ v_note_off) && (OMNI || v_channel == RX_CH);
    if (panic) begin
      for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_age[i] = 0; end
      m_busy_left = 0;
    end else if (m_busy_left == 0) begin
      if (qual) begin
        p_chan = int'(v_channel); p_note = int'(v_note_num); p_vel = int'(v_note_velocity);
        p_on = v_note_on && (v_note_velocity != 0);
        m_busy_left = N + 1;
      end
    end else begin
      m_drop = qual;
      m_busy_left--;
      if (m_busy_left == 0) model_commit();
    end
  endtask

  function automatic logic [N-1:0] pk_gate();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_gate[i];
    return r;
  endfunction
  function automatic logic [7*N-1:0] pk_note();
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*i +: 7] = 7'(m_note[i]);
    return r;
  endfunction
  function automatic logic [7*N-1:0] pk_vel();
    logic [7*N-1:0] r;
    for (int i = 0; i < N; i++) r[7*i +: 7] = 7'(m_vel[i]);
    return r;
  endfunction
  function automatic logic [4*N-1:0] pk_chan();
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_chan[i]);
    return r;
  endfunction

  // One clock: model advances at the edge, control returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_ev(input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v,
                        input logic on, input logic off);
    v_valid = 1'b1; v_channel = ch; v_note_num = n; v_note_velocity = v;
    v_note_on = on; v_note_off = off;
  endtask

  task automatic clr_ev();
    v_valid = 1'b0; v_note_on = 1'b0; v_note_off = 1'b0; panic = 1'b0;
  endtask

  task automatic send_on(input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
    set_ev(ch, n, v, 1'b1, 1'b0);
    tick();
    clr_ev();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 50) begin tick(); k++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, k);
    end
  endtask

  task automatic do_panic();
    panic = 1'b1;
    tick();
    panic = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({busy, ev_dropped, voice_gate, voice_trig} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/drop/gate/trig=%b required all 0",
               {busy, ev_dropped, voice_gate, voice_trig});
    end
    checks++;
    if ({voice_note, voice_vel, voice_chan} !== '0) begin
      errors++;
      $display("FAIL reset_data: note/vel/chan=%h required 0", {voice_note, voice_vel, voice_chan});
    end
    $display("test_reset done");
  endtask

  task automatic test_single_note();
    do_panic();
    send_on(4'd1, 7'd60, 7'd100);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b required 1", busy); end
    for (int k = 1; k <= N; k++) begin
      tick();
      checks++;
      if (voice_gate !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_latency: edge %0d gate=%b busy=%b required 0000/1", k, voice_gate, busy);
      end
    end
    tick();
    checks++;
    if (voice_gate !== 4'b0001 || voice_trig !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_gate: gate=%b trig=%b busy=%b required 0001/0001/0", voice_gate, voice_trig, busy);
    end
    checks++;
    if (voice_note[6:0] !== 7'd60 || voice_vel[6:0] !== 7'd100 || voice_chan[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL single_data: note=%0d vel=%0d chan=%0d required 60/100/1",
               voice_note[6:0], voice_vel[6:0], voice_chan[3:0]);
    end
    tick();
    checks++;
    if (voice_trig !== '0) begin errors++; $display("FAIL single_trig_pulse: trig=%b required 0000", voice_trig); end
    $display("test_single_note done");
  endtask

  task automatic test_steal();
    do_panic();
    for (int k = 0; k < 4; k++) begin
      send_on(4'd0, 7'(60 + k), 7'd90);
      wait_idle("steal_fill");
    end
    send_on(4'd0, 7'd64, 7'd77);
    wait_idle("steal");
    checks++;
    if (voice_gate !== 4'b1111 || voice_trig !== 4'b0001) begin
      errors++;
      $display("FAIL steal_gate: gate=%b trig=%b required 1111/0001", voice_gate, voice_trig);
    end
    checks++;
    if (voice_note !== {7'd63, 7'd62, 7'd61, 7'd64}) begin
      errors++;
      $display("FAIL steal_notes: notes=%h required %h", voice_note, {7'd63, 7'd62, 7'd61, 7'd64});
    end
    $display("test_steal done");
  endtask

  task automatic test_retrigger();
    do_panic();
    send_on(4'd1, 7'd60, 7'd100);
    wait_idle("retrig1");
    send_on(4'd1, 7'd60, 7'd50);
    wait_idle("retrig2");
    checks++;
    if (voice_gate !== 4'b0001 || voice_trig !== 4'b0001 || voice_vel[6:0] !== 7'd50) begin
      errors++;
      $display("FAIL retrigger: gate=%b trig=%b vel0=%0d required 0001/0001/50",
               voice_gate, voice_trig, voice_vel[6:0]);
    end
    $display("test_retrigger done");
  endtask

  task automatic test_vel0_off();
    do_panic();
    send_on(4'd1, 7'd60, 7'd100);
    wait_idle("vel0_on");
    send_on(4'd1, 7'd60, 7'd0);
    wait_idle("vel0_off");
    checks++;
    if (voice_gate !== 4'b0000 || voice_trig !== 4'b0000 || voice_note[6:0] !== 7'd60) begin
      errors++;
      $display("FAIL vel0_off: gate=%b trig=%b note0=%0d required 0000/0000/60",
               voice_gate, voice_trig, voice_note[6:0]);
    end
    $display("test_vel0_off done");
  endtask

  task automatic test_drop();
    do_panic();
    send_on(4'd2, 7'd70, 7'd10);
    tick();
    set_ev(4'd2, 7'd71, 7'd11, 1'b1, 1'b0);
    tick();
    clr_ev();
    checks++;
    if (ev_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: ev_dropped=%b required 1", ev_dropped); end
    tick();
    checks++;
    if (ev_dropped !== 1'b0) begin errors++; $display("FAIL drop_width: ev_dropped=%b required 0", ev_dropped); end
    wait_idle("drop");
    checks++;
    if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd70) begin
      errors++;
      $display("FAIL drop_state: gate=%b note0=%0d required 0001/70", voice_gate, voice_note[6:0]);
    end
    // An event coinciding with the commit edge is also dropped.
    send_on(4'd2, 7'd72, 7'd12);
    repeat (N) tick();
    set_ev(4'd2, 7'd73, 7'd13, 1'b1, 1'b0);
    tick();
    clr_ev();
    checks++;
    if (ev_dropped !== 1'b1 || busy !== 1'b0 || voice_gate !== 4'b0011) begin
      errors++;
      $display("FAIL drop_commit_edge: drop=%b busy=%b gate=%b required 1/0/0011", ev_dropped, busy, voice_gate);
    end
    $display("test_drop done");
  endtask

  task automatic test_panic();
    do_panic();
    for (int k = 0; k < 3; k++) begin
      send_on(4'd0, 7'(40 + k), 7'd64);
      wait_idle("panic_fill");
    end
    send_on(4'd0, 7'd50, 7'd64);
    tick();
    set_ev(4'd0, 7'd51, 7'd64, 1'b1, 1'b0);
    panic = 1'b1;
    tick();
    clr_ev();
    checks++;
    if (voice_gate !== '0 || busy !== 1'b0 || voice_trig !== '0 || ev_dropped !== 1'b0) begin
      errors++;
      $display("FAIL panic_abort: gate=%b busy=%b trig=%b drop=%b required 0000/0/0000/0",
               voice_gate, busy, voice_trig, ev_dropped);
    end
    for (int k = 0; k < N + 2; k++) begin
      tick();
      checks++;
      if (voice_gate !== '0 || voice_trig !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL panic_no_commit: cycle %0d gate=%b trig=%b busy=%b required 0", k, voice_gate, voice_trig, busy);
      end
    end
    $display("test_panic done");
  endtask

  task automatic test_reset_mid_scan();
    do_panic();
    send_on(4'd3, 7'd30, 7'd30);
    wait_idle("rst_fill");
    send_on(4'd3, 7'd31, 7'd31);
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || voice_gate !== '0 || voice_note !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: busy=%b gate=%b note=%h required 0", busy, voice_gate, voice_note);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < N + 2; k++) begin
      tick();
      checks++;
      if (voice_gate !== '0 || voice_trig !== '0) begin
        errors++;
        $display("FAIL reset_discard: cycle %0d gate=%b trig=%b required 0", k, voice_gate, voice_trig);
      end
    end
    $display("test_reset_mid_scan done");
  endtask

  task automatic test_random();
    int r;
    do_panic();
    for (int c = 0; c < 400; c++) begin
      clr_ev();
      if ($urandom_range(0, 99) < 45) begin
        r = $urandom_range(0, 9);
        set_ev(4'($urandom_range(0, 2)), 7'($urandom_range(60, 65)),
               ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
               r <= 5 || r == 9, r >= 6);
        if ($urandom_range(0, 19) == 0) v_valid = 1'b0;
      end
      if ($urandom_range(0, 99) < 2) panic = 1'b1;
      tick();
      checks++;
      if (voice_gate !== pk_gate() || voice_trig !== m_trig) begin
        errors++;
        $display("FAIL rand_gate_trig: cycle %0d gate=%b trig=%b required %b/%b",
                 c, voice_gate, voice_trig, pk_gate(), m_trig);
      end
      checks++;
      if (busy !== (m_busy_left != 0) || ev_dropped !== m_drop) begin
        errors++;
        $display("FAIL rand_busy_drop: cycle %0d busy=%b drop=%b required %b/%b",
                 c, busy, ev_dropped, (m_busy_left != 0), m_drop);
      end
      checks++;
      if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_chan !== pk_chan()) begin
        errors++;
        $display("FAIL rand_data: cycle %0d note=%h vel=%h chan=%h required %h/%h/%h",
                 c, voice_note, voice_vel, voice_chan, pk_note(), pk_vel(), pk_chan());
      end
    end
    clr_ev();
    $display("test_random done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    test_reset();
    test_single_note();
    test_steal();
    test_retrigger();
    test_vel0_off();
    test_drop();
    test_panic();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
